// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (optional perf counters: MC_CTRL_PERF_EN)
module mc_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] dec_inst,
    input  logic       alu_zero,
    input  logic       alu_ovf,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic [2:0] alu_op,
    output logic       alu_imm,
    output logic       ext_sign,
    output logic       halted,
    output logic       bus_err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    // Instruction codes as produced by the decoder.
    localparam logic [5:0] INST_NOP   = 6'd0;
    localparam logic [5:0] INST_ADDU  = 6'd1;
    localparam logic [5:0] INST_SUBU  = 6'd2;
    localparam logic [5:0] INST_SLT   = 6'd3;
    localparam logic [5:0] INST_ORI   = 6'd4;
    localparam logic [5:0] INST_LUI   = 6'd5;
    localparam logic [5:0] INST_ADDI  = 6'd6;
    localparam logic [5:0] INST_ADDIU = 6'd7;
    localparam logic [5:0] INST_LW    = 6'd8;
    localparam logic [5:0] INST_SW    = 6'd9;
    localparam logic [5:0] INST_BEQ   = 6'd10;
    localparam logic [5:0] INST_J     = 6'd11;
    localparam logic [5:0] INST_JAL   = 6'd12;
    localparam logic [5:0] INST_JR    = 6'd13;
    localparam logic [5:0] INST_HLT   = 6'd14;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state, state_nx;
    logic [TO_W-1:0] wd_cnt;
    logic            waiting, ready_sel, wd_fire;
    logic            is_rtype, is_lw, is_sw;
    logic [2:0]      op_d;
    logic            imm_d, sign_d;

    always_comb begin
        waiting   = (state == S_FETCH) || (state == S_MEM);
        ready_sel = (state == S_FETCH) ? imem_ready : dmem_ready;
        // A ready seen in the limit cycle takes priority over the timeout.
        wd_fire   = waiting && !ready_sel && (TIMEOUT != 0) && (wd_cnt == TO_VAL);
        is_rtype  = (dec_inst == INST_ADDU) || (dec_inst == INST_SUBU) || (dec_inst == INST_SLT);
        is_lw     = (dec_inst == INST_LW);
        is_sw     = (dec_inst == INST_SW);
    end

    always_comb begin
        op_d   = 3'd0;
        imm_d  = 1'b0;
        sign_d = 1'b0;
        case (dec_inst)
            INST_SUBU: op_d = 3'd1;
            INST_SLT:  op_d = 3'd3;
            INST_ORI: begin
                op_d  = 3'd2;
                imm_d = 1'b1;
            end
            INST_LUI: begin
                op_d  = 3'd4;
                imm_d = 1'b1;
            end
            INST_ADDI, INST_ADDIU, INST_LW, INST_SW: begin
                imm_d  = 1'b1;
                sign_d = 1'b1;
            end
            INST_BEQ: begin
                op_d   = 3'd1;
                sign_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counter is zero on every entry to FETCH/MEM because it clears whenever not stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (waiting && !ready_sel) begin
            if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (wd_fire) begin
            bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        reg_we   = 1'b0;
        reg_dst  = 2'd0;
        wb_src   = 2'd0;
        alu_op   = 3'd0;
        alu_imm  = 1'b0;
        ext_sign = 1'b0;
        halted   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = S_DECODE;
                end else if (wd_fire) begin
                    state_nx = S_HALT;
                end
            end
            S_DECODE: begin
                case (dec_inst)
                    INST_J: begin
                        pc_we    = 1'b1;
                        pc_src   = 2'd2;
                        state_nx = S_FETCH;
                    end
                    // PC already holds PC+4 here, so the link value is ready.
                    INST_JAL: begin
                        pc_we    = 1'b1;
                        pc_src   = 2'd2;
                        reg_we   = 1'b1;
                        reg_dst  = 2'd2;
                        wb_src   = 2'd2;
                        state_nx = S_FETCH;
                    end
                    INST_JR: begin
                        pc_we    = 1'b1;
                        pc_src   = 2'd3;
                        state_nx = S_FETCH;
                    end
                    INST_HLT: state_nx = S_HALT;
                    INST_NOP: state_nx = S_FETCH;
                    default:  state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_op   = op_d;
                alu_imm  = imm_d;
                ext_sign = sign_d;
                if (dec_inst == INST_BEQ) begin
                    pc_we    = alu_zero;
                    pc_src   = 2'd1;
                    state_nx = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else if ((dec_inst == INST_ADDI) && alu_ovf) begin
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                alu_op   = op_d;
                alu_imm  = imm_d;
                ext_sign = sign_d;
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready) begin
                    state_nx = is_sw ? S_FETCH : S_WB;
                end else if (wd_fire) begin
                    state_nx = S_HALT;
                end
            end
            S_WB: begin
                alu_op   = op_d;
                alu_imm  = imm_d;
                ext_sign = sign_d;
                reg_we   = 1'b1;
                reg_dst  = {1'b0, is_rtype};
                wb_src   = {1'b0, is_lw};
                state_nx = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= 32'd0;
            ret_cnt <= 32'd0;
        end else begin
            if ((state != S_IDLE) && (state != S_HALT)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (((state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB))
                && (state_nx == S_FETCH)) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - instruction-level reference bench for mc_ctrl
module tb_mc_ctrl;

    localparam int TO = 4;

    localparam int NOP = 0, ADDU = 1, SUBU = 2, SLT = 3, ORI = 4, LUI = 5, ADDI = 6,
                   ADDIU = 7, LW = 8, SW = 9, BEQ = 10, J = 11, JAL = 12, JR = 13, HLT = 14;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic [2:0] alu_op;
        logic       alu_imm;
        logic       ext_sign;
        logic       halted;
        logic       bus_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] dec_inst;
    logic       alu_zero, alu_ovf, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic [1:0] pc_src, reg_dst, wb_src;
    logic [2:0] alu_op;
    logic       alu_imm, ext_sign, halted, bus_err;

    vec_t obs;
    int   nvec = 0;
    int   nerr = 0;
    logic m_bus_err;

    mc_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .dec_inst(dec_inst), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
        .alu_op(alu_op), .alu_imm(alu_imm), .ext_sign(ext_sign), .halted(halted),
        .bus_err(bus_err)
    );

    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_src,
                  alu_op, alu_imm, ext_sign, halted, bus_err};

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_ctl(input int code);
        case (code)
            ADDU:                 return {3'd0, 1'b0, 1'b0};
            SUBU:                 return {3'd1, 1'b0, 1'b0};
            SLT:                  return {3'd3, 1'b0, 1'b0};
            ORI:                  return {3'd2, 1'b1, 1'b0};
            LUI:                  return {3'd4, 1'b1, 1'b0};
            ADDI, ADDIU, LW, SW:  return {3'd0, 1'b1, 1'b1};
            BEQ:                  return {3'd1, 1'b0, 1'b1};
            default:              return 5'd0;
        endcase
    endfunction

    task automatic chk(input vec_t e, input string tag);
        #1;
        nvec++;
        assert (obs === e) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        m_bus_err = 1'b0;
        #1;
        nvec++;
        assert (obs === vec_t'(0)) else begin
            nerr++;
            $error("FAIL reset observed=%h expected=%h", obs, vec_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk(vec_t'(0), "idle");
    endtask

    task automatic chk_halt(input int n);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            dec_inst   = 6'($urandom_range(0, 63));
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            e          = '0;
            e.halted   = 1'b1;
            e.bus_err  = m_bus_err;
            chk(e, "halt");
        end
    endtask

    // One instruction from FETCH to completion; iw/dw are ready-low cycles, abort stops mid-MEM.
    task automatic run_instr(input int code, input int iw, input int dw,
                             input logic zero, input logic ovf, input int abort);
        vec_t       e;
        logic [4:0] ac;
        int         nlow;
        ac         = alu_ctl(code);
        dec_inst   = 6'(code);
        alu_zero   = zero;
        alu_ovf    = ovf;
        dmem_ready = 1'($urandom);
        nlow = (iw > TO) ? TO + 1 : iw;
        for (int i = 0; i < nlow; i++) begin
            imem_ready = 1'b0;
            e = '0;
            e.imem_req = 1'b1;
            chk(e, "fetch_wait");
        end
        if (iw > TO) begin
            m_bus_err = 1'b1;
            return;
        end
        imem_ready = 1'b1;
        e = '0;
        e.imem_req = 1'b1;
        e.ir_we    = 1'b1;
        e.pc_we    = 1'b1;
        chk(e, "fetch");
        imem_ready = 1'($urandom);
        e = '0;
        case (code)
            J:   begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
            JAL: begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1;
                       e.reg_dst = 2'd2; e.wb_src = 2'd2; end
            JR:  begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
            default: ;
        endcase
        chk(e, "decode");
        if (code == J || code == JAL || code == JR || code == NOP || code == HLT) return;
        e = '0;
        {e.alu_op, e.alu_imm, e.ext_sign} = ac;
        if (code == BEQ) begin
            e.pc_we  = zero;
            e.pc_src = 2'd1;
        end
        chk(e, "exec");
        if (code == BEQ || (code == ADDI && ovf)) return;
        if (code == LW || code == SW) begin
            e = '0;
            {e.alu_op, e.alu_imm, e.ext_sign} = ac;
            e.dmem_req = 1'b1;
            e.dmem_we  = (code == SW);
            nlow = (dw > TO) ? TO + 1 : dw;
            for (int i = 0; i < nlow; i++) begin
                if (i == abort) return;
                dmem_ready = 1'b0;
                chk(e, "mem_wait");
            end
            if (dw > TO) begin
                m_bus_err = 1'b1;
                return;
            end
            dmem_ready = 1'b1;
            chk(e, "mem");
            dmem_ready = 1'($urandom);
            if (code == SW) return;
        end
        e = '0;
        {e.alu_op, e.alu_imm, e.ext_sign} = ac;
        e.reg_we  = 1'b1;
        e.reg_dst = (code == ADDU || code == SUBU || code == SLT) ? 2'd1 : 2'd0;
        e.wb_src  = (code == LW) ? 2'd1 : 2'd0;
        chk(e, "wb");
    endtask

    initial begin
        dec_inst   = 6'(ADDU);
        alu_zero   = 1'b0;
        alu_ovf    = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        do_reset();

        run_instr(ADDU, 0, 0, 1'b0, 1'b0, -1);
        run_instr(LW, 0, 3, 1'b0, 1'b0, -1);
        run_instr(SW, 0, 3, 1'b0, 1'b0, -1);
        run_instr(BEQ, 0, 0, 1'b1, 1'b0, -1);
        run_instr(BEQ, 0, 0, 1'b0, 1'b0, -1);
        run_instr(JAL, 0, 0, 1'b0, 1'b0, -1);
        run_instr(J, 1, 0, 1'b0, 1'b0, -1);
        run_instr(JR, 2, 0, 1'b0, 1'b0, -1);
        run_instr(NOP, 0, 0, 1'b0, 1'b0, -1);
        run_instr(ADDI, 0, 0, 1'b0, 1'b1, -1);
        run_instr(ADDIU, 0, 0, 1'b0, 1'b1, -1);
        run_instr(ADDI, 0, 0, 1'b0, 1'b0, -1);
        run_instr(ORI, 0, 0, 1'b0, 1'b0, -1);
        run_instr(LUI, 0, 0, 1'b0, 1'b0, -1);
        run_instr(SUBU, 0, 0, 1'b0, 1'b0, -1);
        run_instr(SLT, 0, 0, 1'b0, 1'b0, -1);
        run_instr(ADDU, TO, 0, 1'b0, 1'b0, -1);
        run_instr(LW, 0, TO, 1'b0, 1'b0, -1);

        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 13), $urandom_range(0, TO), $urandom_range(0, TO),
                      1'($urandom), 1'($urandom), -1);
        end

        run_instr(ADDU, TO + 1, 0, 1'b0, 1'b0, -1);
        chk_halt(4);
        do_reset();
        run_instr(SW, 0, TO + 3, 1'b0, 1'b0, -1);
        chk_halt(4);
        do_reset();
        run_instr(HLT, 0, 0, 1'b0, 1'b0, -1);
        chk_halt(8);
        do_reset();
        run_instr(LW, 0, 10, 1'b0, 1'b0, 2);
        do_reset();
        run_instr(ADDU, 0, 0, 1'b0, 1'b0, -1);
        run_instr(LW, 1, 1, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core.
- Consumes the decoder's `INST_* code (dec_inst) each instruction and sequences fetch, decode, execute, memory and write-back.
- Drives all datapath strobes: PC, IR, register file, ALU, memory.
- Owns the instruction/data memory request handshakes, a memory-wait watchdog, and the halt state.

Parameters:
- TIMEOUT, 255: max cycles waiting for imem_ready/dmem_ready before bus error; 0 disables the watchdog.
- TO_W, 8: watchdog counter width; TIMEOUT must fit.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_inst  in  6  decoded instruction code (`INST_* from defines.v), valid from DECODE onward
- alu_zero  in  1  ALU result == 0
- alu_ovf  in  1  signed add overflow (ADDI)
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write (SW), qualified by dmem_req
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs value
- reg_we  out  1  register file write
- reg_dst  out  2  0 rt, 1 rd, 2 r31
- wb_src  out  2  0 ALU, 1 memory data, 2 PC (link)
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 SLT, 4 LUI
- alu_imm  out  1  ALU operand B = extended immediate
- ext_sign  out  1  1 sign-extend imm, 0 zero-extend
- halted  out  1  FSM in HALT
- bus_err  out  1  sticky, watchdog expired

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Only the state register, watchdog counter and bus_err are sequential; all strobes are decoded combinationally from state, dec_inst and the ready/flag inputs.
- Reset (rst_n low, async): state=IDLE, counter=0, bus_err=0.
- In IDLE every output is 0. IDLE moves to FETCH unconditionally on the next clock.
- FETCH:
  - imem_req=1 and holds until imem_ready.
  - In the imem_ready cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE:
  - J: pc_we, pc_src=2, then FETCH.
  - JAL: pc_we, pc_src=2, reg_we, reg_dst=2, wb_src=2 (all in the same cycle; PC already holds PC+4), then FETCH.
  - JR: pc_we, pc_src=3, then FETCH.
  - HLT: go to HALT.
  - NOP: go to FETCH.
  - Any other code: go to EXEC.
- EXEC, ALU controls per instruction (held through MEM/WB):
  - ADDU: op 0, alu_imm 0.
  - SUBU: op 1, alu_imm 0.
  - SLT: op 3, alu_imm 0.
  - ORI: op 2, imm, ext_sign 0.
  - LUI: op 4, imm.
  - ADDI/ADDIU/LW/SW: op 0, imm, ext_sign 1.
  - BEQ: op 1, alu_imm 0, ext_sign 1.
- EXEC exits:
  - BEQ: pc_we=alu_zero, pc_src=1, then FETCH.
  - LW/SW: go to MEM.
  - ADDI with alu_ovf=1: go to FETCH, no write-back.
  - Everything else: go to WB.
- MEM:
  - dmem_req=1, dmem_we=(SW); held until dmem_ready.
  - On dmem_ready: SW goes to FETCH; LW goes to WB.
- WB:
  - reg_we=1 for exactly one cycle, then FETCH.
  - reg_dst: 1 for R-type (ADDU/SUBU/SLT), 0 otherwise.
  - wb_src: 1 for LW, 0 otherwise.
- Watchdog:
  - Counter clears on entering FETCH or MEM, and increments each cycle the relevant ready is low.
  - When the count reaches TIMEOUT with ready still low: set bus_err, go to HALT. Counter saturates.
  - TIMEOUT=0: never fires.
  - A ready arriving in the same cycle the count hits TIMEOUT wins: no error.
- HALT: absorbing, all strobes 0, halted=1. Left only via reset.
- Reset asserted mid-instruction: immediate return to IDLE, strobes drop asynchronously, no partial writes after the edge.
- Latency, zero wait states: R-type/ORI/LUI/ADDI(U) 4 cycles, LW 5, SW 4, BEQ 3, J/JAL/JR 2.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- When defined, adds outputs cyc_cnt[31:0] and ret_cnt[31:0]:
  - cyc_cnt counts every non-IDLE, non-HALT cycle.
  - ret_cnt increments once per completed instruction: the cycle the FSM returns to FETCH from DECODE/EXEC/MEM/WB, excluding HLT.
  - Both counters reset to 0, wrap at 2^32, and freeze in HALT.
- When undefined: ports and logic absent, behaviour otherwise identical.

Test Plan:
- Reset release with imem_ready=1, dec_inst=ADDU: IDLE → FETCH → DECODE → EXEC → WB; reg_we=1, reg_dst=1 in WB only, 4 cycles after IDLE.
- LW with dmem_ready delayed 3 cycles: dmem_req held 4 cycles with dmem_we=0, then WB with wb_src=1; SW variant: dmem_we=1, no reg_we.
- BEQ with alu_zero=1 → pc_we=1, pc_src=1 in EXEC; alu_zero=0 → pc_we=0; JAL → reg_dst=2, wb_src=2, pc_src=2 in DECODE.
- ADDI with alu_ovf=1 → no reg_we, next state FETCH; ADDIU with alu_ovf=1 → WB write occurs.
- TIMEOUT=4, imem_ready held 0 → bus_err=1, halted=1 after 5 FETCH cycles; ready arriving on the 4th count → no error.
- HLT decoded → halted=1 and all strobes 0 indefinitely; rst_n pulsed low mid-MEM → outputs 0 asynchronously, FSM restarts in IDLE.
